// File: rtl/outc_sw_alloc.sv
// Output-port switch allocator and link output register.
// Arbitrates the five input channels with round-robin priority, holds the
// output for the winning channel until its tail flit is accepted (wormhole
// lock), and registers the accepted flit onto the link.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | output free; arbitrate among eligible requests, no grants
// ACTIVE | output locked to owner; grant follows nrdy[ovch_lk]
module outc_sw_alloc #(
   parameter int PORTID   = 0,
   parameter int ROUTERID = 0,
   parameter int DATAW    = 31,
   parameter int PORTW    = 2,
   parameter int VCH      = 1,
   parameter int VCHW     = 0,
   parameter int TYPE_MSB = 31,
   parameter int TYPE_LSB = 30,
   parameter logic [TYPE_MSB-TYPE_LSB:0] TYPE_TAIL     = 2'd2,
   parameter logic [TYPE_MSB-TYPE_LSB:0] TYPE_HEADTAIL = 2'd3
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             req_0,
   input  logic             req_1,
   input  logic             req_2,
   input  logic             req_3,
   input  logic             req_4,
   input  logic [PORTW:0]   port_0,
   input  logic [PORTW:0]   port_1,
   input  logic [PORTW:0]   port_2,
   input  logic [PORTW:0]   port_3,
   input  logic [PORTW:0]   port_4,
   input  logic [DATAW:0]   idata_0,
   input  logic [DATAW:0]   idata_1,
   input  logic [DATAW:0]   idata_2,
   input  logic [DATAW:0]   idata_3,
   input  logic [DATAW:0]   idata_4,
   input  logic             ivalid_0,
   input  logic             ivalid_1,
   input  logic             ivalid_2,
   input  logic             ivalid_3,
   input  logic             ivalid_4,
   input  logic [VCHW:0]    ivch_0,
   input  logic [VCHW:0]    ivch_1,
   input  logic [VCHW:0]    ivch_2,
   input  logic [VCHW:0]    ivch_3,
   input  logic [VCHW:0]    ivch_4,
   input  logic [VCH:0]     nrdy,
   output logic             grt_0,
   output logic             grt_1,
   output logic             grt_2,
   output logic             grt_3,
   output logic             grt_4,
   output logic [DATAW:0]   odata,
   output logic             ovalid,
   output logic [VCHW:0]    ovch,
   output logic             busy
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   localparam logic [PORTW:0] PORT_SEL = (PORTW+1)'(PORTID);

   state_t          state, state_nxt;
   logic [2:0]      owner, owner_nxt;
   logic [2:0]      rr_ptr, rr_ptr_nxt;
   logic [VCHW:0]   ovch_lk, ovch_lk_nxt;

   logic [4:0]      req_v, ivalid_v, elig, grt_v;
   logic [PORTW:0]  port_v  [5];
   logic [DATAW:0]  idata_v [5];
   logic [VCHW:0]   ivch_v  [5];

   logic            found;
   logic [2:0]      winner;
   logic [3:0]      scan_idx;

   logic [DATAW:0]  own_data;
   logic [VCHW:0]   own_vch;
   logic            own_valid;
   logic            own_grt;
   logic            accept;
   logic            is_tail;
   logic [TYPE_MSB-TYPE_LSB:0] own_type;

   assign req_v    = {req_4, req_3, req_2, req_1, req_0};
   assign ivalid_v = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
   assign port_v[0]  = port_0;
   assign port_v[1]  = port_1;
   assign port_v[2]  = port_2;
   assign port_v[3]  = port_3;
   assign port_v[4]  = port_4;
   assign idata_v[0] = idata_0;
   assign idata_v[1] = idata_1;
   assign idata_v[2] = idata_2;
   assign idata_v[3] = idata_3;
   assign idata_v[4] = idata_4;
   assign ivch_v[0]  = ivch_0;
   assign ivch_v[1]  = ivch_1;
   assign ivch_v[2]  = ivch_2;
   assign ivch_v[3]  = ivch_3;
   assign ivch_v[4]  = ivch_4;

   // A request is eligible only when it targets this output port.
   always_comb begin
      elig = '0;
      for (int i = 0; i < 5; i++) begin
         elig[i] = req_v[i] && (port_v[i] == PORT_SEL);
      end
   end

   // Round-robin scan starting at rr_ptr, wrapping modulo 5.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < 5; k++) begin
         scan_idx = {1'b0, rr_ptr} + 4'(k);
         if (scan_idx >= 4'd5) begin
            scan_idx = scan_idx - 4'd5;
         end
         if (!found && elig[scan_idx[2:0]]) begin
            found  = 1'b1;
            winner = scan_idx[2:0];
         end
      end
   end

   // Owner-side mux; grant depends only on state and downstream ready.
   always_comb begin
      own_data  = idata_v[owner];
      own_vch   = ivch_v[owner];
      own_valid = ivalid_v[owner];
      own_grt   = (state == ACTIVE) && nrdy[ovch_lk];
      accept    = own_grt && own_valid;
      own_type  = own_data[TYPE_MSB:TYPE_LSB];
      is_tail   = (own_type == TYPE_TAIL) || (own_type == TYPE_HEADTAIL);
      grt_v     = '0;
      grt_v[owner] = own_grt;
   end

   assign grt_0 = grt_v[0];
   assign grt_1 = grt_v[1];
   assign grt_2 = grt_v[2];
   assign grt_3 = grt_v[3];
   assign grt_4 = grt_v[4];
   assign busy  = (state == ACTIVE);

   // Next-state: lock on arbitration win, release after an accepted tail.
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      rr_ptr_nxt  = rr_ptr;
      ovch_lk_nxt = ovch_lk;
      case (state)
         IDLE: begin
            if (found) begin
               owner_nxt   = winner;
               ovch_lk_nxt = ivch_v[winner];
               state_nxt   = ACTIVE;
            end
         end
         ACTIVE: begin
            if (accept && is_tail) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (owner == 3'd4) ? 3'd0 : owner + 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state   <= IDLE;
         owner   <= '0;
         rr_ptr  <= '0;
         ovch_lk <= '0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         rr_ptr  <= rr_ptr_nxt;
         ovch_lk <= ovch_lk_nxt;
      end
   end

   // Link output register; zeroed whenever no flit is accepted.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         odata  <= '0;
         ovalid <= 1'b0;
         ovch   <= '0;
      end else if (accept) begin
         odata  <= own_data;
         ovalid <= 1'b1;
         ovch   <= own_vch;
      end else begin
         odata  <= '0;
         ovalid <= 1'b0;
         ovch   <= '0;
      end
   end

endmodule

// File: tb/tb_outc_sw_alloc.sv
// Bench for outc_sw_alloc: directed scenarios followed by random traffic,
// all cycles compared against a packet-level reference model.
module tb_outc_sw_alloc;

   localparam logic [1:0] T_HEAD = 2'd0;
   localparam logic [1:0] T_BODY = 2'd1;
   localparam logic [1:0] T_TAIL = 2'd2;
   localparam logic [1:0] T_HT   = 2'd3;

   logic        clk;
   logic        rst_;
   logic        req    [5];
   logic [2:0]  port   [5];
   logic [31:0] idata  [5];
   logic        ivalid [5];
   logic        ivch   [5];
   logic [1:0]  nrdy;
   logic        grt_0, grt_1, grt_2, grt_3, grt_4;
   logic [31:0] odata;
   logic        ovalid;
   logic        ovch;
   logic        busy;
   logic [4:0]  grt_v;

   int checks;
   int failures;

   int          m_holder;
   int          m_prio;
   logic        m_vc;
   logic        m_oval;
   logic [31:0] m_odata;
   logic        m_ovch;

   assign grt_v = {grt_4, grt_3, grt_2, grt_1, grt_0};

   outc_sw_alloc dut (
      .clk(clk), .rst_(rst_),
      .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]), .req_4(req[4]),
      .port_0(port[0]), .port_1(port[1]), .port_2(port[2]), .port_3(port[3]), .port_4(port[4]),
      .idata_0(idata[0]), .idata_1(idata[1]), .idata_2(idata[2]), .idata_3(idata[3]), .idata_4(idata[4]),
      .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]), .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
      .ivch_0(ivch[0]), .ivch_1(ivch[1]), .ivch_2(ivch[2]), .ivch_3(ivch[3]), .ivch_4(ivch[4]),
      .nrdy(nrdy),
      .grt_0(grt_0), .grt_1(grt_1), .grt_2(grt_2), .grt_3(grt_3), .grt_4(grt_4),
      .odata(odata), .ovalid(ovalid), .ovch(ovch), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [29:0] p);
      return {t, p};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 5; i++) begin
         req[i] = 1'b0; port[i] = 3'd0; idata[i] = 32'd0; ivalid[i] = 1'b0; ivch[i] = 1'b0;
      end
      nrdy = 2'b11;
   endtask

   task automatic model_reset();
      m_holder = -1; m_prio = 0; m_vc = 1'b0;
      m_oval = 1'b0; m_odata = 32'd0; m_ovch = 1'b0;
   endtask

   // One clock edge of the reference: who holds the link and what goes out.
   task automatic model_advance();
      int   h;
      logic acc;
      h   = m_holder;
      acc = 1'b0;
      if (h >= 0) begin
         acc = nrdy[m_vc] && ivalid[h];
         if (acc) begin
            m_odata = idata[h]; m_ovch = ivch[h];
            if (idata[h][31:30] == T_TAIL || idata[h][31:30] == T_HT) begin
               m_holder = -1;
               m_prio   = (h + 1) % 5;
            end
         end
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (m_holder < 0 && req[(m_prio + k) % 5] && port[(m_prio + k) % 5] == 3'd0) begin
               m_holder = (m_prio + k) % 5;
               m_vc     = ivch[m_holder];
            end
         end
      end
      m_oval = acc;
      if (!acc) begin
         m_odata = 32'd0; m_ovch = 1'b0;
      end
   endtask

   task automatic check_outputs();
      logic [4:0] eg;
      eg = '0;
      if (m_holder >= 0 && nrdy[m_vc]) eg[m_holder] = 1'b1;
      chk("grant",  grt_v,  eg);
      chk("busy",   busy,   m_holder >= 0);
      chk("ovalid", ovalid, m_oval);
      chk("odata",  odata,  m_odata);
      chk("ovch",   ovch,   m_ovch);
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      @(negedge clk);
      check_outputs();
   endtask

   // Asynchronous reset applied between edges; outputs must clear at once.
   task automatic apply_reset();
      #2;
      rst_ = 1'b0;
      #1;
      chk("rst_odata",  odata,  32'd0);
      chk("rst_ovalid", ovalid, 1'b0);
      chk("rst_ovch",   ovch,   1'b0);
      chk("rst_busy",   busy,   1'b0);
      chk("rst_grant",  grt_v,  5'd0);
      model_reset();
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_ = 1'b1;
   endtask

   initial begin
      int         ov_cnt;
      int         order[$];
      int         exp_rr[6];
      logic [1:0] wt[4];
      checks   = 0;
      failures = 0;
      exp_rr   = '{0, 1, 2, 3, 4, 0};
      wt       = '{T_HEAD, T_BODY, T_BODY, T_TAIL};

      rst_ = 1'b0;
      clear_inputs();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      rst_ = 1'b1;

      // Single HEADTAIL from input 2
      req[2] = 1'b1; idata[2] = mk(T_HT, 30'hA5); ivalid[2] = 1'b1;
      tick();
      chk("s1_grant2", grt_v, 5'b00100);
      req[2] = 1'b0;
      tick();
      chk("s1_ovalid", ovalid, 1'b1);
      chk("s1_odata", odata, 32'hC00000A5);
      chk("s1_busy", busy, 1'b0);
      ivalid[2] = 1'b0;
      req[2] = 1'b1; req[3] = 1'b1; ivalid[3] = 1'b1; idata[3] = mk(T_HT, 30'h33);
      tick();
      chk("s1_rr_ptr3", grt_v, 5'b01000);
      req[2] = 1'b0; req[3] = 1'b0;
      tick();
      clear_inputs();
      tick();

      // Wormhole lock: input 1 packet while input 3 keeps requesting
      req[1] = 1'b1; req[3] = 1'b1;
      tick();
      chk("s2_grant1", grt_v, 5'b00010);
      ov_cnt = 0;
      for (int f = 0; f < 4; f++) begin
         idata[1] = mk(wt[f], 30'(f + 1)); ivalid[1] = 1'b1;
         tick();
         ov_cnt += int'(ovalid);
         chk("s2_grt3_locked", grt_v[3], 1'b0);
      end
      req[1] = 1'b0; ivalid[1] = 1'b0;
      idata[3] = mk(T_HT, 30'h77); ivalid[3] = 1'b1;
      tick();
      ov_cnt += int'(ovalid);
      chk("s2_grant3_late", grt_v, 5'b01000);
      chk("s2_ovalid_count", ov_cnt, 4);
      req[3] = 1'b0;
      tick();
      clear_inputs();
      tick();

      // Round-robin from reset
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         req[i] = 1'b1; ivalid[i] = 1'b1; idata[i] = mk(T_HT, 30'(16 + i));
      end
      for (int c = 0; c < 11; c++) begin
         tick();
         for (int i = 0; i < 5; i++) if (grt_v[i]) order.push_back(i);
      end
      for (int k = 0; k < 6; k++) begin
         chk("s3_rr_order", (k < order.size()) ? order[k] : 99, exp_rr[k]);
      end
      for (int i = 0; i < 5; i++) req[i] = 1'b0;
      tick();
      clear_inputs();
      tick();

      // Backpressure on VC 0 after the HEAD
      req[0] = 1'b1;
      tick();
      chk("s4_grant0", grt_v, 5'b00001);
      req[0] = 1'b0; idata[0] = mk(T_HEAD, 30'h40); ivalid[0] = 1'b1;
      tick();
      chk("s4_head_out", odata, mk(T_HEAD, 30'h40));
      nrdy = 2'b10; idata[0] = mk(T_BODY, 30'h41);
      #1;
      chk("s4_grt_drop", grt_v[0], 1'b0);
      tick();
      chk("s4_stall1_ovalid", ovalid, 1'b0);
      tick();
      chk("s4_stall2_ovalid", ovalid, 1'b0);
      nrdy = 2'b11;
      #1;
      chk("s4_grt_back", grt_v[0], 1'b1);
      tick();
      chk("s4_body_valid", ovalid, 1'b1);
      chk("s4_body_data", odata, mk(T_BODY, 30'h41));
      idata[0] = mk(T_TAIL, 30'h42);
      tick();
      clear_inputs();
      tick();

      // Port filter and stray valid
      req[4] = 1'b1; port[4] = 3'd1; ivalid[0] = 1'b1; idata[0] = mk(T_HT, 30'hEE);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("s5_no_grant", grt_v, 5'd0);
         chk("s5_no_ovalid", ovalid, 1'b0);
      end
      clear_inputs();
      tick();

      // Reset in the middle of a 4-flit packet
      req[1] = 1'b1;
      tick();
      req[1] = 1'b0; idata[1] = mk(T_HEAD, 30'h51); ivalid[1] = 1'b1;
      tick();
      idata[1] = mk(T_BODY, 30'h52);
      apply_reset();
      req[4] = 1'b1; req[0] = 1'b1;
      tick();
      chk("s6_rr_from0", grt_v, 5'b00001);
      req[4] = 1'b0; req[0] = 1'b0; ivalid[0] = 1'b1; idata[0] = mk(T_HT, 30'h60);
      tick();
      clear_inputs();
      tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 5; i++) begin
            req[i]    = ($urandom_range(0, 3) != 0);
            port[i]   = 3'($urandom_range(0, 4));
            ivalid[i] = 1'($urandom_range(0, 1));
            idata[i]  = $urandom;
            ivch[i]   = 1'($urandom_range(0, 1));
         end
         nrdy[0] = ($urandom_range(0, 4) != 0);
         nrdy[1] = ($urandom_range(0, 4) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/outc_sw_alloc.md
# outc_sw_alloc

Output-port switch allocator and output register for one physical output of the mesh router. Collects the five input channels' `req`/`port` requests, grants one input per packet with round-robin fairness and wormhole locking until the tail flit, muxes the granted channel's `odata`/`ovalid`/`ovch` onto the link and registers it. Sits directly downstream of the input channels: drives their `grt_<PCHID>` inputs and consumes their data outputs.

## Interface
- `PORTID`, 0: output port this instance serves; a request counts only when `port_i == PORTID`.
- `ROUTERID`, 0: router identifier, carried for consistency with sibling blocks; no functional effect.
- `clk` input 1: single clock, all state on rising edge.
- `rst_` input 1: reset, asynchronous, active-low.
- `req_0`..`req_4` input 1 each: request from input channel i.
- `port_0`..`port_4` input `PORTW+1` each: requested output port of channel i.
- `idata_0`..`idata_4` input `DATAW+1` each: flit from channel i. Type field is `[TYPE_MSB:TYPE_LSB]`.
- `ivalid_0`..`ivalid_4` input 1 each: flit valid from channel i.
- `ivch_0`..`ivch_4` input `VCHW+1` each: VC of channel i's flit.
- `nrdy` input `VCH+1`: per-VC ready from the downstream buffer.
- `grt_0`..`grt_4` output 1 each: grant to channel i.
- `odata` output `DATAW+1`: registered link data.
- `ovalid` output 1: registered link valid.
- `ovch` output `VCHW+1`: registered link VC.
- `busy` output 1: high while a packet holds this output.

## Operation
- States: IDLE, ACTIVE. Registers: `owner` (3 bits, 0..4), `rr_ptr` (3 bits, 0..4), `ovch_lk` (`VCHW+1`).
- Eligible(i) = `req_i && port_i == PORTID`.
- IDLE: if any eligible input, winner = first eligible scanning `rr_ptr, rr_ptr+1, ... ` mod 5. Next edge: `owner`<=winner, `ovch_lk`<=`ivch_winner`, state<=ACTIVE. No eligible input: stay IDLE. No grant is issued in IDLE.
- ACTIVE: `grt_owner = nrdy[ovch_lk]` (combinational); all other grants 0. `busy`=1.
- Accepted flit: `grt_owner && ivalid_owner`. On accept, next edge: `odata`<=`idata_owner`, `ovch`<=`ivch_owner`, `ovalid`<=1. Otherwise `ovalid`<=0; `odata` and `ovch`<=0.
- Accepted flit of type `TYPE_TAIL` or `TYPE_HEADTAIL`: next edge state<=IDLE, `rr_ptr`<=(owner+1) mod 5 (wrap 4->0).
- `ivalid_j`/`idata_j` from non-owners are ignored; `ivalid_owner` without grant is ignored (no output).
- Owner dropping `req` mid-packet does not release the lock; only a tail does.
- `nrdy[ovch_lk]` low: grant drops the same cycle, no flit sent, state held.

## Timing
- Reset (async assert): state IDLE, `owner`=0, `rr_ptr`=0, `ovch_lk`=0, `odata`=0, `ovalid`=0, `ovch`=0, `busy`=0, all `grt_i`=0. Reset mid-packet abandons the packet with no tail emitted.
- Request to first grant: 1 cycle (request seen in IDLE cycle N, grant in N+1 if downstream ready).
- Accepted flit to `ovalid`: 1 cycle.
- Throughput: one flit per cycle while `nrdy` stays high.
- Back-to-back packets: one IDLE arbitration cycle between a tail and the next packet's grant.
- `grt_i` depends combinationally on `nrdy` only; no combinational path from `ivalid`/`idata` to any output.

## Test plan
- Single HEADTAIL: `req_2`=1, `port_2`=PORTID, `nrdy`=1. Cycle 1: `grt_2`=1. Drive `idata_2`=HEADTAIL flit 0x...A5. Cycle 2: `ovalid`=1, `odata` equals that flit. Cycle 3: IDLE, `busy`=0, `rr_ptr`=3.
- Wormhole lock: input 1 sends HEAD, BODY, BODY, TAIL while input 3 requests throughout. Requirements: `grt_3` stays 0 until input 1's tail is accepted, then input 3 is granted 2 cycles later. `ovalid` is high for exactly 4 cycles during input 1's packet.
- Round-robin: all five inputs request HEADTAIL packets continuously from reset. Grant order must be 0,1,2,3,4,0, with wrap at 4->0.
- Backpressure: during a 3-flit packet, drop `nrdy`[0] for 2 cycles after the HEAD. Requirements: `grt_owner`=0 and `ovalid`=0 in the cycles following, and BODY is accepted when `nrdy` returns.
- Port filter/ignored valids: `req_4`=1 with `port_4`≠PORTID, plus stray `ivalid_0` with no request. Requirement: no grant and `ovalid` stays 0.
- Reset mid-packet: assert `rst_`=0 after the HEAD of a 4-flit packet. Requirement: all outputs 0 immediately. After release, a new request is granted from `rr_ptr`=0.
